// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser arbiter.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MOTOR,
        WAIT_DROP,
        REPORT
    } vend_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_EMPTY   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BADPROD = 2'b11;

    localparam int unsigned PROD_COFFEE = 0;
    localparam int unsigned PROD_SPRITE = 1;

    function automatic int unsigned vend_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned vend_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i, with wrap.
module vend_rr_picker
    import vend_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = vend_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_valid_o
);

    int unsigned j;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        j           = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(rr_ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_valid_o && req_i[IW'(j)]) begin
                any_valid_o        = 1'b1;
                grant_o[IW'(j)]    = 1'b1;
                grant_idx_o        = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Shares one dispenser between NUM_REQ front-ends: round-robin accept, stock check,
// timed motor pulse, drop wait, completion report. Define VEND_RETRY_EN for one motor retry on timeout.
module vend_dispense_arbiter
    import vend_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 2,
    parameter  int unsigned NUM_PROD       = 2,
    parameter  int unsigned MOTOR_CYCLES   = 8,
    parameter  int unsigned TIMEOUT_CYCLES = 32,
    localparam int unsigned IW             = vend_idx_w(NUM_REQ),
    localparam int unsigned PW             = vend_idx_w(NUM_PROD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*PW-1:0] req_prod,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_PROD-1:0]   stock_empty,
    input  logic                  drop_sensor,
    output logic [NUM_PROD-1:0]   motor_en,
    output logic                  done_valid,
    output logic [IW-1:0]         done_id,
    output logic [1:0]            done_err,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(vend_max(MOTOR_CYCLES, TIMEOUT_CYCLES) + 1);

    vend_state_e   state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          flag_q, flag_d;
    logic [1:0]    err_q, err_d;
`ifdef VEND_RETRY_EN
    logic          retry_q, retry_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               any_valid;
    logic [PW-1:0]      sel_prod;
    logic               prod_empty;

    vend_rr_picker #(.N(NUM_REQ)) u_picker (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_valid_o (any_valid)
    );

    assign sel_prod   = req_prod[grant_idx*PW +: PW];
    assign prod_empty = |(stock_empty & (NUM_PROD'(1) << prod_q));
    // Saturating increment so the counter can never wrap.
    assign cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            err_q    <= ERR_OK;
`ifdef VEND_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
`ifdef VEND_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        flag_d     = flag_q;
        err_d      = err_q;
`ifdef VEND_RETRY_EN
        retry_d    = retry_q;
`endif
        req_ready  = '0;
        motor_en   = '0;
        done_valid = 1'b0;
        done_id    = '0;
        done_err   = ERR_OK;
        busy       = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (any_valid) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    prod_d    = sel_prod;
                    rr_ptr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IW'(1);
                    state_d   = CHECK;
                end
            end
            CHECK: begin
`ifdef VEND_RETRY_EN
                retry_d = 1'b0;
`endif
                if (32'(prod_q) >= NUM_PROD) begin
                    err_d   = ERR_BADPROD;
                    state_d = REPORT;
                end else if (prod_empty) begin
                    err_d   = ERR_EMPTY;
                    state_d = REPORT;
                end else begin
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    state_d = MOTOR;
                end
            end
            MOTOR: begin
                motor_en = NUM_PROD'(1) << prod_q;
                if (drop_sensor) begin
                    flag_d = 1'b1;
                end
                // Motor always runs the full pulse; the drop is only judged at its end.
                if (cnt_q == CW'(MOTOR_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (flag_q || drop_sensor) begin
                        err_d   = ERR_OK;
                        state_d = REPORT;
                    end else begin
                        state_d = WAIT_DROP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DROP: begin
                if (drop_sensor) begin
                    err_d   = ERR_OK;
                    state_d = REPORT;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
`ifdef VEND_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        cnt_d   = '0;
                        flag_d  = 1'b0;
                        state_d = MOTOR;
                    end else begin
                        err_d   = ERR_TIMEOUT;
                        state_d = REPORT;
                    end
`else
                    err_d   = ERR_TIMEOUT;
                    state_d = REPORT;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REPORT: begin
                done_valid = 1'b1;
                done_id    = id_q;
                done_err   = err_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
- Shares one dispenser mechanism between NUM_REQ independent vending front-ends; each front-end is a coin/selection FSM.
- Accepts dispense requests with round-robin fairness.
- Checks stock, then pulses the selected product motor for a fixed time and waits for the drop sensor.
- Reports completion or error to the requester.

Parameters:
- NUM_REQ, 2, number of requesting front-ends (2..8).
- NUM_PROD, 2, number of products/motors (0 = coffee, 1 = sprite).
- MOTOR_CYCLES, 8, clk cycles motor_en is held high per attempt (>=1).
- TIMEOUT_CYCLES, 32, clk cycles to wait for drop_sensor after the motor pulse (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester dispense request; held until accepted.
- req_prod  in  NUM_REQ*PW  product index per requester, PW = clog2(NUM_PROD); slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- stock_empty  in  NUM_PROD  level, 1 = product unavailable.
- drop_sensor  in  1  synchronous level; high = item dropped.
- motor_en  out  NUM_PROD  one-hot motor drive.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  clog2(NUM_REQ)  requester index of the completed job.
- done_err  out  2  00 ok, 01 out of stock, 10 drop timeout, 11 bad product index.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state): FSM = IDLE, rr_ptr = 0, all counters = 0, drop flag = 0; all outputs 0.
- States: IDLE, CHECK, MOTOR, WAIT_DROP, REPORT.
- IDLE:
  - Pick the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[i] = 1 combinationally, same cycle; req_ready is 0 in all other states.
  - On transfer: latch id and prod, set rr_ptr = (id+1) mod NUM_REQ, go to CHECK.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- CHECK, one cycle:
  - prod >= NUM_PROD: err = 11, go to REPORT.
  - else stock_empty[prod]: err = 01, go to REPORT.
  - else clear cycle counter and drop flag, go to MOTOR.
- MOTOR:
  - motor_en[prod] = 1 for exactly MOTOR_CYCLES cycles.
  - drop_sensor high in any MOTOR cycle sets the drop flag; the motor still runs the full count.
  - At the end: flag set gives err = 00 and goes to REPORT; otherwise clear counter and go to WAIT_DROP.
- WAIT_DROP:
  - drop_sensor high gives err = 00 and goes to REPORT next cycle.
  - After TIMEOUT_CYCLES cycles without a drop, err = 10, go to REPORT.
  - drop_sensor in the final timeout cycle counts as ok.
- REPORT, one cycle: done_valid = 1 with done_id and done_err valid; then IDLE.
- Latency:
  - Out-of-stock: transfer edge to done_valid is 2 cycles.
  - Success with drop seen during MOTOR: 2 + MOTOR_CYCLES cycles.
- Simultaneous requests: exactly one is granted per IDLE visit. Losers keep req_valid high and win on later visits in round-robin order.
- stock_empty is sampled only in CHECK; changes during MOTOR are ignored.
- req_valid deasserted before transfer: no grant, no side effects.
- Reset mid-job: motor_en drops immediately (async); the job is lost, with no done pulse.
- Counters saturate and never wrap.
- Counter width = clog2(max(MOTOR_CYCLES, TIMEOUT_CYCLES) + 1).

Optional Feature:
- Macro VEND_RETRY_EN.
- Defined: the first drop timeout does not report. The block re-enters MOTOR once with counter and flag cleared; only a second timeout yields err = 10.
  - A per-job retry bit is cleared in CHECK.
  - Worst-case latency = 2 + 2*(MOTOR_CYCLES + TIMEOUT_CYCLES) cycles.
- Undefined: the first timeout goes directly to REPORT with err = 10; the retry bit and its logic are absent.

Decomposition:
- Shared package vend_pkg holds:
  - state enum;
  - error codes ERR_OK, ERR_EMPTY, ERR_TIMEOUT, ERR_BADPROD;
  - product codes PROD_COFFEE = 0, PROD_SPRITE = 1.
- Sub-module vend_rr_picker (parameter N):
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational; instantiated once.

Test Plan:
- Out of stock: req_valid = 01, req_prod[0] = 0, stock_empty = 01 -> req_ready = 01 for one cycle; done_valid 2 cycles after transfer with done_id = 0, done_err = 01; motor_en never asserted.
- Success: req0 prod = 1, stock ok, drop_sensor pulsed in MOTOR cycle 3 -> motor_en = 10 for exactly 8 cycles; done_err = 00 at transfer+10; busy low afterwards.
- Round-robin: req_valid = 11 held, drop always immediate -> grants in order 0, 1, 0, 1; done_id follows the same sequence.
- Timeout, macro undefined: drop_sensor never high -> motor 8 cycles, 32 wait cycles, done_err = 10 at transfer+42.
- Timeout with VEND_RETRY_EN, drop_sensor never high -> two 8-cycle motor pulses; done_err = 10 at transfer+82.
- Timeout with VEND_RETRY_EN, drop on retry -> done_err = 00.
- Reset during MOTOR cycle 4 -> motor_en = 0 and busy = 0 immediately; no done_valid; after release a new request is granted from rr_ptr = 0.
